bus_serial_rx: RTL and testbench

Parametrised serial frame receiver for the system bus slave side. Shifts in an address field on `rx_address` and, for write frames, a data field on `rx_data`, one bit per qualified clock. It then presents the completed address/data as a registered word with a one-cycle `frame_valid` strobe. Supports configurable widths, bit order, read/write frames, stall cycles and frame abort/restart.

---
 rtl/bus_serial_rx.sv | 127 ++++++++++++
 tb/tb_bus_serial_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_serial_rx.sv
// Serial frame receiver: shifts in an address field and, for write frames, a data field,
// then presents the completed frame as registered outputs with a one-cycle valid strobe.
module bus_serial_rx #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_start,
    input  logic                  rx_mode,
    input  logic                  rx_valid,
    input  logic                  rx_address,
    input  logic                  rx_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_byte_out,
    output logic                  frame_valid,
    output logic                  frame_write,
    output logic                  busy,
    output logic                  frame_err,
    output logic [1:0]            state_dbg
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int IDX_W = $clog2(MAX_W + 1);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    addr_t            addr_sr, addr_sr_n, address_n;
    data_t            data_sr, data_sr_n, data_n;
    logic             mode, mode_n;
    logic             fv_n, fw_n, err_n;
    int               addr_pos, data_pos;

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        addr_sr_n = addr_sr;
        data_sr_n = data_sr;
        mode_n    = mode;
        address_n = address;
        data_n    = data_byte_out;
        fv_n      = 1'b0;
        fw_n      = frame_write;
        err_n     = 1'b0;
        addr_pos  = LSB_FIRST ? int'(bit_idx) : ADDR_WIDTH - 1 - int'(bit_idx);
        data_pos  = LSB_FIRST ? int'(bit_idx) : DATA_WIDTH - 1 - int'(bit_idx);

        // A start always (re)opens a frame; when one was already open it is dropped.
        if (rx_start) begin
            state_n   = ADDR;
            bit_idx_n = '0;
            addr_sr_n = '0;
            data_sr_n = '0;
            mode_n    = rx_mode;
            err_n     = (state != IDLE);
        end else if (rx_valid) begin
            case (state)
                ADDR: begin
                    addr_sr_n = addr_sr | (addr_t'(rx_address) << addr_pos);
                    if (bit_idx == IDX_W'(ADDR_WIDTH - 1)) begin
                        bit_idx_n = '0;
                        if (mode) begin
                            state_n = DATA;
                        end else begin
                            state_n   = IDLE;
                            address_n = addr_sr_n;
                            fv_n      = 1'b1;
                            fw_n      = 1'b0;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
                DATA: begin
                    data_sr_n = data_sr | (data_t'(rx_data) << data_pos);
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        bit_idx_n = '0;
                        state_n   = IDLE;
                        address_n = addr_sr;
                        data_n    = data_sr_n;
                        fv_n      = 1'b1;
                        fw_n      = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_idx       <= '0;
            addr_sr       <= '0;
            data_sr       <= '0;
            mode          <= 1'b0;
            address       <= '0;
            data_byte_out <= '0;
            frame_valid   <= 1'b0;
            frame_write   <= 1'b0;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_n;
            bit_idx       <= bit_idx_n;
            addr_sr       <= addr_sr_n;
            data_sr       <= data_sr_n;
            mode          <= mode_n;
            address       <= address_n;
            data_byte_out <= data_n;
            frame_valid   <= fv_n;
            frame_write   <= fw_n;
            busy          <= (state_n != IDLE);
            frame_err     <= err_n;
        end
    end

endmodule

// File: tb/tb_bus_serial_rx.sv
// Bench for bus_serial_rx: directed frames, stalls, aborts, reset and random frames on a
// 12/8 LSB-first instance, plus a 4/4 MSB-first instance, against a frame-level model.
module tb_bus_serial_rx;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_start, rx_mode, rx_valid, rx_address, rx_data;
    logic [AW-1:0] address;
    logic [DW-1:0] data_byte_out;
    logic          frame_valid, frame_write, busy, frame_err;
    logic [1:0]    state_dbg;

    logic          s_start, s_mode, s_valid, s_abit, s_dbit;
    logic [3:0]    s_address, s_data;
    logic          s_fv, s_fw, s_busy, s_err;
    logic [1:0]    s_state;

    int errors = 0;
    int checks = 0;

    // frame-level model of the last completed frame and whether a frame is open
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_write;
    logic          in_frame;
    logic [3:0]    s_exp_data;
    int            stall_a[AW];
    int            stall_d[DW];

    always #5 clk = ~clk;

    bus_serial_rx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_start(rx_start), .rx_mode(rx_mode),
        .rx_valid(rx_valid), .rx_address(rx_address), .rx_data(rx_data),
        .address(address), .data_byte_out(data_byte_out), .frame_valid(frame_valid),
        .frame_write(frame_write), .busy(busy), .frame_err(frame_err), .state_dbg(state_dbg)
    );

    bus_serial_rx #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .rx_start(s_start), .rx_mode(s_mode),
        .rx_valid(s_valid), .rx_address(s_abit), .rx_data(s_dbit),
        .address(s_address), .data_byte_out(s_data), .frame_valid(s_fv),
        .frame_write(s_fw), .busy(s_busy), .frame_err(s_err), .state_dbg(s_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // i-th bit on the wire for a field of the given width and order
    function automatic logic ser_bit(input logic [31:0] value, input int width, input int i,
                                     input bit lsb);
        return lsb ? 1'(value >> i) : 1'(value >> (width - 1 - i));
    endfunction

    task automatic clear_stalls();
        foreach (stall_a[i]) stall_a[i] = 0;
        foreach (stall_d[i]) stall_d[i] = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"}, address, 0);
        check({tag, "_data"}, data_byte_out, 0);
        check({tag, "_fv"}, frame_valid, 0);
        check({tag, "_fw"}, frame_write, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    // Start plus nbits unstalled bits of a frame that is left open.
    task automatic send_bits(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int nbits);
        rx_start = 1'b1;
        rx_mode  = mode;
        tick();
        rx_start = 1'b0;
        in_frame = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            rx_valid   = 1'b1;
            rx_address = (i < AW) ? ser_bit(a, AW, i, 1'b1) : 1'($urandom);
            rx_data    = (i < AW) ? 1'($urandom) : ser_bit(d, DW, i - AW, 1'b1);
            tick();
            check("partial_fv", frame_valid, 0);
        end
        rx_valid = 1'b0;
    endtask

    // Full frame with the stalls in stall_a/stall_d; leaves the bench in the frame_valid cycle.
    task automatic run_frame(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n          = mode ? AW + DW : AW;
        rx_start   = 1'b1;
        rx_mode    = mode;
        rx_valid   = 1'($urandom);
        rx_address = 1'($urandom);
        rx_data    = 1'($urandom);
        tick();
        rx_start = 1'b0;
        rx_mode  = 1'($urandom);
        check("start_err", frame_err, in_frame);
        check("start_busy", busy, 1);
        check("start_fv", frame_valid, 0);
        check("start_addr_held", address, exp_addr);
        in_frame = 1'b1;
        for (int i = 0; i < n; i++) begin
            bit is_addr;
            int k;
            int stalls;
            is_addr    = (i < AW);
            k          = is_addr ? i : i - AW;
            stalls     = is_addr ? stall_a[k] : stall_d[k];
            rx_valid   = 1'b1;
            rx_address = is_addr ? ser_bit(a, AW, k, 1'b1) : 1'($urandom);
            rx_data    = is_addr ? 1'($urandom) : ser_bit(d, DW, k, 1'b1);
            tick();
            if (i != n - 1) begin
                check("bit_fv", frame_valid, 0);
                check("bit_busy", busy, 1);
                for (int s = 0; s < stalls; s++) begin
                    rx_valid   = 1'b0;
                    rx_address = 1'($urandom);
                    rx_data    = 1'($urandom);
                    tick();
                    check("stall_fv", frame_valid, 0);
                    check("stall_busy", busy, 1);
                end
            end
        end
        rx_valid  = 1'b0;
        exp_addr  = a;
        exp_write = mode;
        if (mode) exp_data = d;
        in_frame  = 1'b0;
        check("done_fv", frame_valid, 1);
        check("done_busy", busy, 0);
        check("done_err", frame_err, 0);
        check("done_addr", address, exp_addr);
        check("done_data", data_byte_out, exp_data);
        check("done_write", frame_write, exp_write);
    endtask

    task automatic run_small(input logic mode, input logic [3:0] a, input logic [3:0] d);
        int n;
        n       = mode ? 8 : 4;
        s_start = 1'b1;
        s_mode  = mode;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_abit  = (i < 4) ? ser_bit(a, 4, i, 1'b0) : 1'b0;
            s_dbit  = (i < 4) ? 1'b0 : ser_bit(d, 4, i - 4, 1'b0);
            tick();
            if (i != n - 1) check("msb_bit_fv", s_fv, 0);
        end
        s_valid = 1'b0;
        if (mode) s_exp_data = d;
        check("msb_fv", s_fv, 1);
        check("msb_addr", s_address, a);
        check("msb_data", s_data, s_exp_data);
        check("msb_write", s_fw, mode);
    endtask

    initial begin
        reset = 1'b1;
        rx_start = 1'b0; rx_mode = 1'b0; rx_valid = 1'b0; rx_address = 1'b0; rx_data = 1'b0;
        s_start = 1'b0; s_mode = 1'b0; s_valid = 1'b0; s_abit = 1'b0; s_dbit = 1'b0;
        exp_addr = '0; exp_data = '0; exp_write = 1'b0; in_frame = 1'b0; s_exp_data = '0;
        clear_stalls();
        tick();
        tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // write frame 0xA5C/0x3E, no stalls: valid 20 cycles after start
        run_frame(1'b1, 12'hA5C, 8'h3E);
        // back-to-back read frame 0x123
        run_frame(1'b0, 12'h123, 8'h00);
        tick();
        check("hold_fv", frame_valid, 0);
        check("hold_addr", address, 12'h123);
        check("hold_data", data_byte_out, 8'h3E);
        check("hold_write", frame_write, 0);

        // stalls: 3 after address bit 5, 2 after data bit 0
        stall_a[5] = 3;
        stall_d[0] = 2;
        run_frame(1'b1, 12'h0F0, 8'h81);
        clear_stalls();

        // MSB-first 4/4 instance
        run_small(1'b1, 4'h9, 4'h6);
        run_small(1'b0, 4'hC, 4'h0);

        // abort after 7 address bits, then a full write frame
        send_bits(1'b1, 12'h3A7, 8'h5B, 7);
        run_frame(1'b1, 12'h555, 8'hAA);
        tick();
        check("after_abort_err", frame_err, 0);

        // reset after 15 bits of a write frame
        send_bits(1'b1, 12'hFFF, 8'hFF, 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outputs_zero("midreset");
        exp_addr = '0; exp_data = '0; exp_write = 1'b0; in_frame = 1'b0;
        run_frame(1'b1, 12'h001, 8'h01);

        // random frames with random stalls and occasional aborts, back-to-back
        for (int f = 0; f < 16; f++) begin
            logic          m;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            foreach (stall_a[i]) stall_a[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            foreach (stall_d[i]) stall_d[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 3) == 0) begin
                m = 1'($urandom);
                send_bits(m, 12'($urandom), 8'($urandom),
                          $urandom_range(1, m ? AW + DW - 1 : AW - 1));
            end
            m  = 1'($urandom);
            ra = 12'($urandom);
            rd = 8'($urandom);
            run_frame(m, ra, rd);
        end
        tick();
        check("final_fv", frame_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
